// File: rtl/ebi_read_responder.sv
// -----------------------------------------------------------------------------
// ebi_read_responder
//
// FPGA-side read path for the MCU's multiplexed 16-bit EBI bus. It is the
// companion to the write-path EBI interface.
//   * Latches the address phase while ALE (active low) is asserted.
//   * On a falling edge of RE (active low), issues a one-cycle read request
//     to the internal register/memory fabric.
//   * Drives the returned word onto EBI_AD through EBI_AD_oe until RE is
//     released.
//   * Substitutes DEFAULT_DATA if the fabric does not answer within
//     TIMEOUT_CYCLES WAIT cycles.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   EBI_AD_in  - pad input of the multiplexed address/data bus
//   EBI_AD_out - pad output value
//   EBI_AD_oe  - pad output enable (1 = FPGA drives EBI_AD)
//   EBI_ALE    - address latch enable, active low
//   EBI_RE     - read strobe, active low
//   rd_addr    - address of the current read request
//   rd_req     - one-cycle read request pulse
//   rd_valid   - fabric response valid
//   rd_data    - fabric response data
//   busy       - high whenever the FSM is not IDLE
//   timeout    - one-cycle pulse when DEFAULT_DATA is substituted
// -----------------------------------------------------------------------------
module ebi_read_responder #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    SYNC_STAGES    = 2,
    parameter int                    TIMEOUT_CYCLES = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_DATA   = 16'hDEAD
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] EBI_AD_in,
    output logic [DATA_WIDTH-1:0] EBI_AD_out,
    output logic                  EBI_AD_oe,
    input  logic                  EBI_ALE,
    input  logic                  EBI_RE,
    output logic [DATA_WIDTH-1:0] rd_addr,
    output logic                  rd_req,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRIVE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers. AD gets a delay line of the same depth as the
    // strobes so that the address seen by the latch lines up with ALE.
    // sync_vld_reg fills with ones after reset and marks the point where
    // the strobe synchronizer outputs reflect real pad samples rather than
    // reset values.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] ale_sync_reg;
    logic [SYNC_STAGES-1:0] re_sync_reg;
    logic [SYNC_STAGES-1:0] sync_vld_reg;
    logic [DATA_WIDTH-1:0]  ad_dly_reg [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ale_sync_reg <= '1;
            re_sync_reg  <= '1;
            sync_vld_reg <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                ad_dly_reg[i] <= '0;
            end
        end else begin
            ale_sync_reg <= {ale_sync_reg[SYNC_STAGES-2:0], EBI_ALE};
            re_sync_reg  <= {re_sync_reg[SYNC_STAGES-2:0], EBI_RE};
            sync_vld_reg <= {sync_vld_reg[SYNC_STAGES-2:0], 1'b1};
            ad_dly_reg[0] <= EBI_AD_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ad_dly_reg[i] <= ad_dly_reg[i-1];
            end
        end
    end

    logic                  ale_s;
    logic                  re_s;
    logic                  pad_seen;
    logic [DATA_WIDTH-1:0] ad_s;

    assign ale_s    = ale_sync_reg[SYNC_STAGES-1];
    assign re_s     = re_sync_reg[SYNC_STAGES-1];
    assign pad_seen = sync_vld_reg[SYNC_STAGES-1];
    assign ad_s     = ad_dly_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Address latch: transparent-in-time while synced ALE is low, holds
    // otherwise. Independent of the FSM so an address phase is never lost.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] addr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg <= '0;
        end else if (!ale_s) begin
            addr_reg <= ad_s;
        end
    end

    // ------------------------------------------------------------------
    // RE falling-edge detection. re_armed_reg only sets once a genuine
    // high level of RE has been observed after reset, so a strobe that was
    // already low when reset was released does not look like a new read.
    // ------------------------------------------------------------------
    logic re_prev_reg;
    logic re_armed_reg;
    logic re_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            re_prev_reg  <= 1'b1;
            re_armed_reg <= 1'b0;
        end else begin
            re_prev_reg <= re_s;
            if (pad_seen && re_s) begin
                re_armed_reg <= 1'b1;
            end
        end
    end

    assign re_fall = re_armed_reg && re_prev_reg && !re_s;

    // ------------------------------------------------------------------
    // Read FSM with registered outputs.
    // ------------------------------------------------------------------
    state_t                state_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [DATA_WIDTH-1:0] ad_out_reg;
    logic                  ad_oe_reg;
    logic [DATA_WIDTH-1:0] rd_addr_reg;
    logic                  rd_req_reg;
    logic                  busy_reg;
    logic                  timeout_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            ad_out_reg  <= '0;
            ad_oe_reg   <= 1'b0;
            rd_addr_reg <= '0;
            rd_req_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            rd_req_reg  <= 1'b0;
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (re_fall) begin
                        state_reg   <= ST_REQ;
                        rd_req_reg  <= 1'b1;
                        rd_addr_reg <= addr_reg;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    state_reg <= ST_WAIT;
                    cnt_reg   <= '0;
                end
                ST_WAIT: begin
                    // An early strobe release wins over any same-cycle
                    // response or timeout: the MCU is no longer listening.
                    if (re_s) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else if (rd_valid) begin
                        state_reg  <= ST_DRIVE;
                        ad_out_reg <= rd_data;
                        ad_oe_reg  <= 1'b1;
                    end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES)) begin
                        state_reg   <= ST_DRIVE;
                        ad_out_reg  <= DEFAULT_DATA;
                        ad_oe_reg   <= 1'b1;
                        timeout_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (re_s) begin
                        state_reg <= ST_IDLE;
                        ad_oe_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ad_oe_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign EBI_AD_out = ad_out_reg;
    assign EBI_AD_oe  = ad_oe_reg;
    assign rd_addr    = rd_addr_reg;
    assign rd_req     = rd_req_reg;
    assign busy       = busy_reg;
    assign timeout    = timeout_reg;

endmodule
